// File: rtl/dm_arbiter_pkg.sv
// Shared encodings and widths for the data-memory arbiter.
package dm_arbiter_pkg;

  localparam int DM_AW = 8;
  localparam int DM_DW = 8;

  typedef enum logic {
    CPU_PRI   = 1'b0,
    EXT_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    EXT  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dm_read_return.sv
// Remembers who owns the in-flight read and steers mem_dout back to that port.
module dm_read_return
  import dm_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_issue_i,
  input  rd_owner_e        rd_owner_i,
  input  logic [DM_DW-1:0] mem_dout_i,
  output logic             cpu_rvalid_o,
  output logic [DM_DW-1:0] cpu_rdata_o,
  output logic             ext_rvalid_o,
  output logic [DM_DW-1:0] ext_rdata_o
);

  rd_owner_e        owner_q, owner_d;
  logic [DM_DW-1:0] cpu_hold_q, ext_hold_q;

  assign owner_d = rd_issue_i ? rd_owner_i : NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= NONE;
      cpu_hold_q <= '0;
      ext_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == CPU) cpu_hold_q <= mem_dout_i;
      if (owner_q == EXT) ext_hold_q <= mem_dout_i;
    end
  end

  // The non-owner keeps presenting the last data it was handed.
  always_comb begin
    cpu_rvalid_o = 1'b0;
    ext_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    ext_rdata_o  = '0;
    if (!rst) begin
      cpu_rvalid_o = (owner_q == CPU);
      ext_rvalid_o = (owner_q == EXT);
      cpu_rdata_o  = (owner_q == CPU) ? mem_dout_i : cpu_hold_q;
      ext_rdata_o  = (owner_q == EXT) ? mem_dout_i : ext_hold_q;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: CPU first, EXT protected by a starvation limit and allowed short bursts.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DM_AW-1:0] cpu_addr,
  input  logic [DM_DW-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [DM_DW-1:0] cpu_rdata,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [DM_AW-1:0] ext_addr,
  input  logic [DM_DW-1:0] ext_wdata,
  output logic             ext_gnt,
  output logic             ext_rvalid,
  output logic [DM_DW-1:0] ext_rdata,
  output logic             mem_we,
  output logic [DM_AW-1:0] mem_addr,
  output logic [DM_DW-1:0] mem_din,
  input  logic [DM_DW-1:0] mem_dout,
  output logic             busy_ext
);

  localparam logic [3:0] MW = 4'(MAX_WAIT);
  localparam logic [3:0] BM = 4'(BURST_MAX);

  arb_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] beat_q, beat_d;
  logic       cpu_win, ext_win;
  logic       cpu_gnt, ext_g;
  logic       rd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU_PRI;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    unique case (state_q)
      CPU_PRI: begin
        if (cpu_req && !(ext_req && wait_q == MW)) cpu_win = 1'b1;
        else if (ext_req)                          ext_win = 1'b1;
      end
      EXT_BURST: begin
        if (ext_req && beat_q < BM) begin
          ext_win = 1'b1;
        end else begin
          // Burst over: CPU gets this same cycle, EXT is shut out.
          cpu_win = cpu_req;
          state_d = CPU_PRI;
          beat_d  = '0;
        end
      end
      default: ;
    endcase
    if (ext_win) begin
      state_d = EXT_BURST;
      beat_d  = (state_q == CPU_PRI) ? 4'd1 : beat_q + 4'd1;
      wait_d  = '0;
    end else if (ext_req) begin
      wait_d  = (wait_q >= MW) ? MW : wait_q + 4'd1;
    end else begin
      wait_d  = '0;
    end
  end

  assign cpu_gnt  = cpu_win && !rst;
  assign ext_g    = ext_win && !rst;
  assign rd_issue = (cpu_gnt && !cpu_we) || (ext_g && !ext_we);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    ext_gnt   = ext_g;
    cpu_stall = !rst && cpu_req && !cpu_win;
    busy_ext  = !rst && (state_q == EXT_BURST);
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (ext_g) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_din  = ext_wdata;
    end
  end

  dm_read_return u_rr (
    .clk          (clk),
    .rst          (rst),
    .rd_issue_i   (rd_issue),
    .rd_owner_i   (ext_g ? EXT : CPU),
    .mem_dout_i   (mem_dout),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .ext_rvalid_o (ext_rvalid),
    .ext_rdata_o  (ext_rdata)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed scenarios plus randomized traffic, scored against a rule-level model of the arbiter.
module tb_dm_arbiter;

  localparam int MW = 4;
  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic       cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_we, busy_ext;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_WAIT(MW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy_ext(busy_ext)
  );

  // Synchronous-read memory behind the arbiter, preloaded with addr ^ 8'hB5.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  // Reference model: contents, EXT blocked-run length, EXT burst length, pending read.
  logic [7:0] ref_mem [256];
  bit         in_burst;
  int         burst_len, blocked_run;
  int         pend_owner;       // 0 none, 1 cpu, 2 ext
  logic [7:0] pend_data, cpu_last, ext_last;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_burst = 0; burst_len = 0; blocked_run = 0;
    pend_owner = 0; pend_data = 8'h00; cpu_last = 8'h00; ext_last = 8'h00;
  endtask

  // One clock: drive, check combinational outputs, advance model at the edge.
  task automatic step(input bit r,
                      input bit creq, input bit cwe, input logic [7:0] ca, input logic [7:0] cw,
                      input bit ereq, input bit ewe, input logic [7:0] ea, input logic [7:0] ew,
                      output bit cpu_won, output bit ext_won);
    bit cwin, ewin;
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    ext_req = ereq; ext_we = ewe; ext_addr = ea; ext_wdata = ew;
    #1;
    cwin = 0; ewin = 0;
    if (in_burst && ereq && burst_len < BM)  ewin = 1;
    else if (in_burst)                        cwin = creq;
    else if (creq && !(ereq && blocked_run >= MW)) cwin = 1;
    else if (ereq)                            ewin = 1;
    if (r) begin cwin = 0; ewin = 0; end

    chk1("cpu_stall", cpu_stall, !r && creq && !cwin);
    chk1("ext_gnt", ext_gnt, ewin);
    chk1("mem_we", mem_we, cwin ? cwe : (ewin ? ewe : 1'b0));
    chk8("mem_addr", mem_addr, cwin ? ca : (ewin ? ea : 8'h00));
    chk8("mem_din", mem_din, cwin ? cw : (ewin ? ew : 8'h00));
    chk1("busy_ext", busy_ext, !r && in_burst);
    chk1("cpu_rvalid", cpu_rvalid, !r && pend_owner == 1);
    chk1("ext_rvalid", ext_rvalid, !r && pend_owner == 2);
    chk8("cpu_rdata", cpu_rdata, r ? 8'h00 : (pend_owner == 1 ? pend_data : cpu_last));
    chk8("ext_rdata", ext_rdata, r ? 8'h00 : (pend_owner == 2 ? pend_data : ext_last));

    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (pend_owner == 1) cpu_last = pend_data;
      if (pend_owner == 2) ext_last = pend_data;
      pend_owner = 0;
      if (cwin && !cwe) begin pend_owner = 1; pend_data = ref_mem[ca]; end
      if (ewin && !ewe) begin pend_owner = 2; pend_data = ref_mem[ea]; end
      if (cwin && cwe) ref_mem[ca] = cw;
      if (ewin && ewe) ref_mem[ea] = ew;
      if (ewin) begin
        burst_len   = in_burst ? burst_len + 1 : 1;
        in_burst    = 1;
        blocked_run = 0;
      end else begin
        in_burst    = 0;
        burst_len   = 0;
        blocked_run = ereq ? ((blocked_run + 1 > MW) ? MW : blocked_run + 1) : 0;
      end
    end
    cpu_won = cwin; ext_won = ewin;
    @(negedge clk);
  endtask

  task automatic idle(input bit r);
    bit a, b;
    step(r, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, a, b);
  endtask

  initial begin
    bit cw, ew;
    int idx;
    bit e_pend, e_we;
    logic [7:0] e_addr, e_data;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB5;
    model_reset();
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    @(negedge clk);

    // Reset cycles with requests present: outputs must stay quiet.
    step(1, 1, 1, 8'h11, 8'h22, 1, 1, 8'h33, 8'h44, cw, ew);
    idle(1);

    // Single CPU read of 0x10.
    step(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, cw, ew);
    chk1("t1_rvalid", cpu_rvalid, 1'b1);
    chk8("t1_rdata", cpu_rdata, 8'hA5);
    idle(0);

    // Both requesting: CPU for MAX_WAIT cycles, then EXT forced through.
    for (int k = 0; k <= MW; k++)
      step(0, 1, 0, 8'(8'h60 + k), 8'h00, 1, 0, 8'h40, 8'h00, cw, ew);
    chk1("t2_busy", busy_ext, 1'b1);
    idle(0); idle(0);

    // EXT write burst against a continuously requesting CPU.
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      step(0, 1, 0, 8'h50, 8'h00, 1, 1, 8'(8'h20 + idx), 8'(idx + 1), cw, ew);
      if (ew) idx++;
    end
    chk8("t3_beats", 8'(idx), 8'd6);
    idle(0);
    for (int i = 0; i < 6; i++) chk8("t3_mem", mem[8'(8'h20 + i)], 8'(i + 1));
    idle(0);

    // EXT read then CPU read on consecutive cycles.
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, cw, ew);
    step(0, 1, 0, 8'h31, 8'h00, 0, 0, 8'h00, 8'h00, cw, ew);
    chk1("t4_cpu_rv", cpu_rvalid, 1'b1);
    chk8("t4_cpu_rd", cpu_rdata, 8'h84);
    chk1("t4_ext_rv", ext_rvalid, 1'b0);
    chk8("t4_ext_rd", ext_rdata, 8'h85);
    idle(0);

    // Reset while bursting with an EXT read in flight.
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h77, 8'h00, cw, ew);
    step(1, 1, 0, 8'h12, 8'h00, 1, 0, 8'h78, 8'h00, cw, ew);
    chk1("t5_ext_rv", ext_rvalid, 1'b0);
    chk1("t5_busy", busy_ext, 1'b0);

    // Quiet bus.
    for (int k = 0; k < 10; k++) idle(0);

    // Random traffic; EXT holds each transaction until granted.
    e_pend = 0; e_we = 0; e_addr = 0; e_data = 0;
    for (int k = 0; k < 400; k++) begin
      if (!e_pend && $urandom_range(0, 1) == 1) begin
        e_pend = 1; e_we = 1'($urandom_range(0, 1));
        e_addr = 8'($urandom_range(0, 255)); e_data = 8'($urandom_range(0, 255));
      end
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           e_pend, e_we, e_addr, e_data, cw, ew);
      if (ew) e_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
